// File: rtl/axil_reg_sequencer_if.sv
// AXI4-Lite master bundle for the register sequencer (AW, W, B, AR, R channels).
// Latency: none, wires only.
// Backpressure: plain AXI valid/ready on every channel; master drives valids, slave drives readies.
// Ports: master modport drives addresses/data/valids and bready/rready;
//        slave modport drives awready/wready/arready, bresp/bvalid, rdata/rresp/rvalid.
interface axil_reg_sequencer_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   m_axi_awaddr;
   logic [2:0]              m_axi_awprot;
   logic                    m_axi_awvalid;
   logic                    m_axi_awready;
   logic [DATA_WIDTH-1:0]   m_axi_wdata;
   logic [DATA_WIDTH/8-1:0] m_axi_wstrb;
   logic                    m_axi_wvalid;
   logic                    m_axi_wready;
   logic [1:0]              m_axi_bresp;
   logic                    m_axi_bvalid;
   logic                    m_axi_bready;
   logic [ADDR_WIDTH-1:0]   m_axi_araddr;
   logic [2:0]              m_axi_arprot;
   logic                    m_axi_arvalid;
   logic                    m_axi_arready;
   logic [DATA_WIDTH-1:0]   m_axi_rdata;
   logic [1:0]              m_axi_rresp;
   logic                    m_axi_rvalid;
   logic                    m_axi_rready;

   modport master (
      output m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
      input  m_axi_awready,
      output m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
      input  m_axi_wready,
      input  m_axi_bresp, m_axi_bvalid,
      output m_axi_bready,
      output m_axi_araddr, m_axi_arprot, m_axi_arvalid,
      input  m_axi_arready,
      input  m_axi_rdata, m_axi_rresp, m_axi_rvalid,
      output m_axi_rready
   );

   modport slave (
      input  m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
      output m_axi_awready,
      input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
      output m_axi_wready,
      output m_axi_bresp, m_axi_bvalid,
      input  m_axi_bready,
      input  m_axi_araddr, m_axi_arprot, m_axi_arvalid,
      output m_axi_arready,
      output m_axi_rdata, m_axi_rresp, m_axi_rvalid,
      input  m_axi_rready
   );
endinterface

// File: rtl/axil_reg_sequencer.sv
// Two-requester round-robin sequencer issuing single AXI4-Lite register reads/writes.
// Latency: grant at T, AXI valid at T+1, response at T+2, done pulse at T+3 with a zero-wait slave.
// Backpressure: one transaction in flight; requesters wait on cN_ready, AXI stalls hold each valid.
// Ports: ACLK/ARESET (sync, active high); cN_valid/we/addr/wdata/wstrb command in with cN_ready
//        accept pulse; cN_done pulse with cN_rdata/cN_resp result; axi = AXI4-Lite master bundle.
module axil_reg_sequencer #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    ACLK,
   input  logic                    ARESET,
   input  logic                    c0_valid,
   output logic                    c0_ready,
   input  logic                    c0_we,
   input  logic [ADDR_WIDTH-1:0]   c0_addr,
   input  logic [DATA_WIDTH-1:0]   c0_wdata,
   input  logic [DATA_WIDTH/8-1:0] c0_wstrb,
   output logic                    c0_done,
   output logic [DATA_WIDTH-1:0]   c0_rdata,
   output logic [1:0]              c0_resp,
   input  logic                    c1_valid,
   output logic                    c1_ready,
   input  logic                    c1_we,
   input  logic [ADDR_WIDTH-1:0]   c1_addr,
   input  logic [DATA_WIDTH-1:0]   c1_wdata,
   input  logic [DATA_WIDTH/8-1:0] c1_wstrb,
   output logic                    c1_done,
   output logic [DATA_WIDTH-1:0]   c1_rdata,
   output logic [1:0]              c1_resp,
   axil_reg_sequencer_if.master    axi
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WR      = 3'd1;
   localparam logic [2:0] S_WR_RESP = 3'd2;
   localparam logic [2:0] S_RD_ADDR = 3'd3;
   localparam logic [2:0] S_RD_DATA = 3'd4;
   localparam logic [2:0] S_DONE    = 3'd5;

   logic [2:0]            state;
   logic                  last_grant;   // requester granted most recently
   logic                  cur;          // requester owning the transaction in flight
   logic [ADDR_WIDTH-3:0] cap_word;     // captured word address, byte offset dropped
   logic [DATA_WIDTH-1:0] cap_wdata;
   logic [STRB_WIDTH-1:0] cap_wstrb;

   logic                  grant0;
   logic                  grant1;
   logic                  sel_we;
   logic [ADDR_WIDTH-3:0] sel_word;
   logic [DATA_WIDTH-1:0] sel_wdata;
   logic [STRB_WIDTH-1:0] sel_wstrb;
   logic                  aw_pend;
   logic                  w_pend;

   // Byte offsets are discarded: every access is a full aligned word.
   logic unused_addr_lsbs;
   assign unused_addr_lsbs = ^{c0_addr[1:0], c1_addr[1:0]};

   // Round-robin: under contention the requester that did not win last time
   // takes the slot. Gated by reset so no accept pulse leaks out while held.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (state == S_IDLE && !ARESET) begin
         grant0 = c0_valid && (!c1_valid || last_grant);
         grant1 = c1_valid && (!c0_valid || !last_grant);
      end
   end

   always_comb begin
      sel_we    = c0_we;
      sel_word  = c0_addr[ADDR_WIDTH-1:2];
      sel_wdata = c0_wdata;
      sel_wstrb = c0_wstrb;
      if (grant1) begin
         sel_we    = c1_we;
         sel_word  = c1_addr[ADDR_WIDTH-1:2];
         sel_wdata = c1_wdata;
         sel_wstrb = c1_wstrb;
      end
   end

   assign c0_ready = grant0;
   assign c1_ready = grant1;
   assign c0_done  = (state == S_DONE) && !cur;
   assign c1_done  = (state == S_DONE) && cur;

   // A channel is still pending when its valid is up and this cycle's ready is not.
   assign aw_pend = axi.m_axi_awvalid && !axi.m_axi_awready;
   assign w_pend  = axi.m_axi_wvalid && !axi.m_axi_wready;

   assign axi.m_axi_awaddr = {cap_word, 2'b00};
   assign axi.m_axi_araddr = {cap_word, 2'b00};
   assign axi.m_axi_awprot = 3'b000;
   assign axi.m_axi_arprot = 3'b000;
   assign axi.m_axi_wdata  = cap_wdata;
   assign axi.m_axi_wstrb  = cap_wstrb;

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state             <= S_IDLE;
         last_grant        <= 1'b1;
         cur               <= 1'b0;
         cap_word          <= '0;
         cap_wdata         <= '0;
         cap_wstrb         <= '0;
         axi.m_axi_awvalid <= 1'b0;
         axi.m_axi_wvalid  <= 1'b0;
         axi.m_axi_bready  <= 1'b0;
         axi.m_axi_arvalid <= 1'b0;
         axi.m_axi_rready  <= 1'b0;
         c0_rdata          <= '0;
         c0_resp           <= 2'b00;
         c1_rdata          <= '0;
         c1_resp           <= 2'b00;
      end else begin
         case (state)
            S_IDLE: begin
               if (grant0 || grant1) begin
                  cur        <= grant1;
                  last_grant <= grant1;
                  cap_word   <= sel_word;
                  cap_wdata  <= sel_wdata;
                  cap_wstrb  <= sel_wstrb;
                  if (sel_we) begin
                     axi.m_axi_awvalid <= 1'b1;
                     axi.m_axi_wvalid  <= 1'b1;
                     state             <= S_WR;
                  end else begin
                     axi.m_axi_arvalid <= 1'b1;
                     state             <= S_RD_ADDR;
                  end
               end
            end
            S_WR: begin
               // AW and W complete independently; each valid falls after its own handshake.
               if (!aw_pend) axi.m_axi_awvalid <= 1'b0;
               if (!w_pend)  axi.m_axi_wvalid  <= 1'b0;
               if (!aw_pend && !w_pend) begin
                  axi.m_axi_bready <= 1'b1;
                  state            <= S_WR_RESP;
               end
            end
            S_WR_RESP: begin
               if (axi.m_axi_bvalid) begin
                  axi.m_axi_bready <= 1'b0;
                  if (cur) c1_resp <= axi.m_axi_bresp;
                  else     c0_resp <= axi.m_axi_bresp;
                  state <= S_DONE;
               end
            end
            S_RD_ADDR: begin
               if (axi.m_axi_arready) begin
                  axi.m_axi_arvalid <= 1'b0;
                  axi.m_axi_rready  <= 1'b1;
                  state             <= S_RD_DATA;
               end
            end
            S_RD_DATA: begin
               if (axi.m_axi_rvalid) begin
                  axi.m_axi_rready <= 1'b0;
                  if (cur) begin
                     c1_rdata <= axi.m_axi_rdata;
                     c1_resp  <= axi.m_axi_rresp;
                  end else begin
                     c0_rdata <= axi.m_axi_rdata;
                     c0_resp  <= axi.m_axi_rresp;
                  end
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axil_reg_sequencer.sv
// Bench for axil_reg_sequencer: AXI4-Lite slave model with programmable stalls,
// per-requester scoreboard queues filled on accept and drained on done pulses.
// Ports: all DUT ports driven/observed; the AXI bundle is an interface instance.
module tb_axil_reg_sequencer;

   logic        ACLK = 1'b0;
   logic        ARESET;
   logic        c0_valid, c0_ready, c0_we, c0_done;
   logic [3:0]  c0_addr, c0_wstrb;
   logic [31:0] c0_wdata, c0_rdata;
   logic [1:0]  c0_resp;
   logic        c1_valid, c1_ready, c1_we, c1_done;
   logic [3:0]  c1_addr, c1_wstrb;
   logic [31:0] c1_wdata, c1_rdata;
   logic [1:0]  c1_resp;

   axil_reg_sequencer_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) axi ();

   axil_reg_sequencer #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .c0_valid(c0_valid), .c0_ready(c0_ready), .c0_we(c0_we), .c0_addr(c0_addr),
      .c0_wdata(c0_wdata), .c0_wstrb(c0_wstrb), .c0_done(c0_done), .c0_rdata(c0_rdata),
      .c0_resp(c0_resp),
      .c1_valid(c1_valid), .c1_ready(c1_ready), .c1_we(c1_we), .c1_addr(c1_addr),
      .c1_wdata(c1_wdata), .c1_wstrb(c1_wstrb), .c1_done(c1_done), .c1_rdata(c1_rdata),
      .c1_resp(c1_resp),
      .axi(axi)
   );

   always #5 ACLK = ~ACLK;

   int cyc = 0;
   always @(posedge ACLK) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- AXI4-Lite slave model ----------------
   int          aw_wait = 0, w_wait = 0, r_wait = 0;
   logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
   int          aw_c, w_c, r_c;
   logic        aw_got, w_got, rd_pend;
   logic [3:0]  wa;
   logic [31:0] wd, rd_q;
   logic [3:0]  ws;
   logic [31:0] smem [4];

   assign axi.m_axi_awready = axi.m_axi_awvalid && (aw_c >= aw_wait);
   assign axi.m_axi_wready  = axi.m_axi_wvalid && (w_c >= w_wait);
   assign axi.m_axi_arready = axi.m_axi_arvalid;
   assign axi.m_axi_bvalid  = aw_got && w_got;
   assign axi.m_axi_bresp   = bresp_cfg;
   assign axi.m_axi_rvalid  = rd_pend && (r_c >= r_wait);
   assign axi.m_axi_rresp   = rresp_cfg;
   assign axi.m_axi_rdata   = rd_q;

   always @(posedge ACLK) begin
      if (ARESET) begin
         aw_c <= 0; w_c <= 0; r_c <= 0;
         aw_got <= 1'b0; w_got <= 1'b0; rd_pend <= 1'b0;
         wa <= '0; wd <= '0; ws <= '0; rd_q <= '0;
      end else begin
         if (axi.m_axi_awvalid && axi.m_axi_awready) begin
            aw_got <= 1'b1; wa <= axi.m_axi_awaddr; aw_c <= 0;
         end else if (axi.m_axi_awvalid) aw_c <= aw_c + 1;
         if (axi.m_axi_wvalid && axi.m_axi_wready) begin
            w_got <= 1'b1; wd <= axi.m_axi_wdata; ws <= axi.m_axi_wstrb; w_c <= 0;
         end else if (axi.m_axi_wvalid) w_c <= w_c + 1;
         if (axi.m_axi_bvalid && axi.m_axi_bready) begin
            for (int b = 0; b < 4; b++)
               if (ws[b]) smem[wa[3:2]][8*b +: 8] <= wd[8*b +: 8];
            aw_got <= 1'b0; w_got <= 1'b0;
         end
         if (axi.m_axi_arvalid && axi.m_axi_arready) begin
            rd_pend <= 1'b1; rd_q <= smem[axi.m_axi_araddr[3:2]]; r_c <= 0;
         end else if (axi.m_axi_rvalid && axi.m_axi_rready) begin
            rd_pend <= 1'b0; r_c <= 0;
         end else if (rd_pend) r_c <= r_c + 1;
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct packed {
      logic        is_rd;
      logic [1:0]  resp;
      logic [31:0] rdata;
   } exp_t;

   exp_t        q0[$];
   exp_t        q1[$];
   logic [31:0] model_mem [4];
   logic [31:0] m_rdata0 = '0, m_rdata1 = '0;

   task automatic push_exp(input int n, input logic we, input logic [3:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb);
      exp_t e;
      e.is_rd = !we;
      e.resp  = we ? bresp_cfg : rresp_cfg;
      e.rdata = model_mem[addr[3:2]];
      if (we)
         for (int b = 0; b < 4; b++)
            if (strb[b]) model_mem[addr[3:2]][8*b +: 8] = wdata[8*b +: 8];
      if (n == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   // Present a command, hold it until accepted, then withdraw it.
   task automatic send(input int n, input logic we, input logic [3:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb);
      int  budget = 300;
      bit  got = 0;
      @(negedge ACLK);
      if (n == 0) begin c0_valid = 1; c0_we = we; c0_addr = addr; c0_wdata = wdata; c0_wstrb = strb; end
      else        begin c1_valid = 1; c1_we = we; c1_addr = addr; c1_wdata = wdata; c1_wstrb = strb; end
      while (!got && budget > 0) begin
         #1;
         if ((n == 0) ? c0_ready : c1_ready) begin
            got = 1;
            push_exp(n, we, addr, wdata, strb);
         end
         @(negedge ACLK);
         budget--;
      end
      if (n == 0) c0_valid = 0; else c1_valid = 0;
      check("grant_seen", {31'd0, got}, 32'd1);
   endtask

   task automatic drain();
      int b = 0;
      while ((q0.size() != 0 || q1.size() != 0) && b < 300) begin
         @(negedge ACLK);
         b++;
      end
      check("drain_done", {31'd0, (q0.size() == 0 && q1.size() == 0)}, 32'd1);
      repeat (2) @(negedge ACLK);
   endtask

   // ---------------- monitor ----------------
   bit   grant_log[$];
   int   grant_cyc, done_cyc, aw_first, w_first, br_first;
   int   aw_cnt, w_cnt, rr_cnt, n_done0 = 0, n_done1 = 0;
   logic [3:0] aw_addr_seen;
   logic prev_d0 = 1'b0, prev_d1 = 1'b0;

   task automatic handle_done(input int n);
      exp_t e;
      int   qs;
      qs = (n == 0) ? q0.size() : q1.size();
      check("done_expected", {31'd0, qs != 0}, 32'd1);
      if (qs != 0) begin
         if (n == 0) begin
            e = q0.pop_front();
            check("c0_resp", {30'd0, c0_resp}, {30'd0, e.resp});
            check("c0_rdata", c0_rdata, e.is_rd ? e.rdata : m_rdata0);
            if (e.is_rd) m_rdata0 = e.rdata;
         end else begin
            e = q1.pop_front();
            check("c1_resp", {30'd0, c1_resp}, {30'd0, e.resp});
            check("c1_rdata", c1_rdata, e.is_rd ? e.rdata : m_rdata1);
            if (e.is_rd) m_rdata1 = e.rdata;
         end
      end
   endtask

   always @(negedge ACLK) begin
      #2;
      if (c0_ready || c1_ready) begin
         check("ready_exclusive", {31'd0, c0_ready & c1_ready}, 32'd0);
         grant_log.push_back(c1_ready);
         grant_cyc = cyc;
         aw_first = -1; w_first = -1; br_first = -1;
         aw_cnt = 0; w_cnt = 0; rr_cnt = 0;
      end
      if (axi.m_axi_awvalid) begin
         if (aw_first < 0) begin aw_first = cyc; aw_addr_seen = axi.m_axi_awaddr; end
         aw_cnt++;
      end
      if (axi.m_axi_wvalid) begin
         if (w_first < 0) w_first = cyc;
         w_cnt++;
      end
      if (axi.m_axi_bready && br_first < 0) br_first = cyc;
      if (axi.m_axi_rready) rr_cnt++;
      if (c0_done) begin
         check("done0_single", {31'd0, prev_d0}, 32'd0);
         done_cyc = cyc; n_done0++;
         handle_done(0);
      end
      if (c1_done) begin
         check("done1_single", {31'd0, prev_d1}, 32'd0);
         done_cyc = cyc; n_done1++;
         handle_done(1);
      end
      prev_d0 = c0_done;
      prev_d1 = c1_done;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int gl, d1;
      for (int i = 0; i < 4; i++) begin smem[i] = '0; model_mem[i] = '0; end
      ARESET = 1;
      c0_valid = 1; c0_we = 0; c0_addr = 0; c0_wdata = 0; c0_wstrb = 0;
      c1_valid = 1; c1_we = 0; c1_addr = 0; c1_wdata = 0; c1_wstrb = 0;
      repeat (3) @(negedge ACLK);
      #2;
      check("rst_valids", {27'd0, axi.m_axi_awvalid, axi.m_axi_wvalid, axi.m_axi_arvalid,
                           axi.m_axi_bready, axi.m_axi_rready}, 32'd0);
      check("rst_ready_done", {28'd0, c0_ready, c1_ready, c0_done, c1_done}, 32'd0);
      check("rst_rdata", c0_rdata | c1_rdata, 32'd0);
      check("rst_resp", {28'd0, c0_resp, c1_resp}, 32'd0);
      check("rst_addr_data", {24'd0, axi.m_axi_awaddr, axi.m_axi_araddr} | axi.m_axi_wdata, 32'd0);
      ARESET = 0; c0_valid = 0; c1_valid = 0;

      // Contention straight out of reset: c0 first, then alternate.
      fork
         begin send(0, 1, 4'h0, 32'h11, 4'hF); send(0, 1, 4'h8, 32'h33, 4'hF); end
         begin send(1, 1, 4'h4, 32'h22, 4'hF); send(1, 1, 4'hC, 32'h44, 4'hF); end
      join
      drain();
      check("rr_count", grant_log.size(), 32'd4);
      for (int i = 0; i < 4; i++)
         if (i < grant_log.size()) check("rr_order", {31'd0, grant_log[i]}, i % 2);

      // Single write, zero-wait slave: latency profile.
      send(0, 1, 4'h4, 32'h0000_0002, 4'hF);
      drain();
      check("wr_aw_lat", 32'(aw_first - grant_cyc), 32'd1);
      check("wr_w_lat", 32'(w_first - grant_cyc), 32'd1);
      check("wr_awaddr", {28'd0, aw_addr_seen}, 32'h4);
      check("wr_b_lat", 32'(br_first - grant_cyc), 32'd2);
      check("wr_done_lat", 32'(done_cyc - grant_cyc), 32'd3);

      // Write then read back every word, plus a partial-strobe write and unaligned reads.
      for (int i = 0; i < 4; i++) send(0, 1, 4'(i * 4), 32'(i + 1), 4'hF);
      for (int i = 0; i < 4; i++) send(0, 0, 4'(i * 4), 32'd0, 4'h0);
      send(1, 1, 4'h9, 32'hAABB_CCDD, 4'h5);
      send(1, 0, 4'hA, 32'd0, 4'h0);
      send(0, 0, 4'h7, 32'd0, 4'h0);
      drain();
      check("rd_aligned_addr", {28'd0, axi.m_axi_araddr}, 32'h4);

      // Skewed write handshake: AW stalls three cycles, W goes through at once.
      aw_wait = 2;
      send(0, 1, 4'hC, 32'h55, 4'hF);
      drain();
      aw_wait = 0;
      check("skew_aw_cycles", aw_cnt, 32'd3);
      check("skew_w_cycles", w_cnt, 32'd1);
      check("skew_bready_at", 32'(br_first - grant_cyc), 32'd4);

      // Slow read data with SLVERR.
      r_wait = 4; rresp_cfg = 2'b10;
      d1 = n_done1;
      send(1, 0, 4'h4, 32'd0, 4'h0);
      drain();
      r_wait = 0; rresp_cfg = 2'b00;
      check("bp_rready_cycles", rr_cnt, 32'd5);
      check("bp_done_pulses", 32'(n_done1 - d1), 32'd1);
      repeat (3) @(negedge ACLK);
      #2 check("bp_resp_hold", {30'd0, c1_resp}, 32'h2);

      // Reset while waiting for read data.
      r_wait = 20;
      send(1, 0, 4'h0, 32'd0, 4'h0);
      for (int i = 0; i < 50 && !axi.m_axi_rready; i++) @(negedge ACLK);
      check("reached_rd_data", {31'd0, axi.m_axi_rready}, 32'd1);
      d1 = n_done1;
      ARESET = 1;
      @(negedge ACLK);
      #2;
      check("midrst_valids", {27'd0, axi.m_axi_awvalid, axi.m_axi_wvalid, axi.m_axi_arvalid,
                              axi.m_axi_bready, axi.m_axi_rready}, 32'd0);
      check("midrst_rdata", c1_rdata, 32'd0);
      q1.delete();
      m_rdata0 = '0; m_rdata1 = '0;
      ARESET = 0; r_wait = 0;
      repeat (5) @(negedge ACLK);
      check("midrst_no_done", 32'(n_done1 - d1), 32'd0);
      gl = grant_log.size();
      fork
         send(0, 1, 4'h0, 32'h77, 4'hF);
         send(1, 1, 4'h4, 32'h88, 4'hF);
      join
      drain();
      if (gl < grant_log.size()) check("midrst_first_grant", {31'd0, grant_log[gl]}, 32'd0);
      else                       check("midrst_grant_seen", grant_log.size(), 32'(gl + 1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/axil_reg_sequencer.md
AXIL_REG_SEQUENCER -- requirements
Module: axil_reg_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, the AXI4-Lite byte address width (4 registers x 32 bit).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, the AXI4-Lite data width; only 32 is supported.
REQ-003 SHALL have port ACLK, input, 1, the single clock; all logic is on the rising edge.
REQ-004 SHALL have port ARESET, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports c0_valid and c1_valid, input, 1, requester N presents a command.
REQ-006 SHALL have ports c0_ready and c1_ready, output, 1, a one-cycle pulse meaning requester N's command is accepted.
REQ-007 SHALL have ports c0_we and c1_we, input, 1: 1 = write, 0 = read.
REQ-008 SHALL have ports c0_addr and c1_addr, input, ADDR_WIDTH, the byte address.
REQ-009 SHALL have ports c0_wdata and c1_wdata, input, 32, write data; also ports c0_wstrb and c1_wstrb, input, 4, byte strobes.
REQ-010 SHALL have ports c0_done and c1_done, output, 1, a one-cycle completion pulse.
REQ-011 SHALL have ports c0_rdata and c1_rdata, output, 32, read data; also ports c0_resp and c1_resp, output, 2, the AXI response.
REQ-012 SHALL have AXI4-Lite master ports as follows.
- m_axi_awaddr, output, ADDR_WIDTH; m_axi_awprot, output, 3; m_axi_awvalid, output, 1; m_axi_awready, input, 1.
- m_axi_wdata, output, 32; m_axi_wstrb, output, 4; m_axi_wvalid, output, 1; m_axi_wready, input, 1.
- m_axi_bresp, input, 2; m_axi_bvalid, input, 1; m_axi_bready, output, 1.
- m_axi_araddr, output, ADDR_WIDTH; m_axi_arprot, output, 3; m_axi_arvalid, output, 1; m_axi_arready, input, 1.
- m_axi_rdata, input, 32; m_axi_rresp, input, 2; m_axi_rvalid, input, 1; m_axi_rready, output, 1.

Function
REQ-013 SHALL implement the FSM states IDLE, WR, WR_RESP, RD_ADDR, RD_DATA and DONE, with only one AXI transaction outstanding at a time.
REQ-014 In IDLE, with any cN_valid high, the block SHALL grant one requester by round-robin.
- A register last_grant holds the requester granted previously.
- If both requesters are valid, the one not equal to last_grant wins.
- If only one is valid, it wins.
REQ-015 On the grant cycle the block SHALL:
- pulse cN_ready for the winner only;
- capture we, addr, wdata and wstrb into internal registers;
- update last_grant.
REQ-016 Captured addresses SHALL be word-aligned: addr[1:0] is forced to 2'b00 on awaddr and araddr.
REQ-017 awprot and arprot SHALL be constant 3'b000.
REQ-018 For a write, in the cycle after the grant, awvalid and wvalid SHALL both assert (state WR).
- Each one drops in the cycle after its own handshake; handshakes may occur on the same or different cycles.
- Each stays stable until its handshake completes.
REQ-019 Once both the AW and W handshakes are complete, the block SHALL enter WR_RESP with bready=1 and hold until bvalid.
REQ-020 For a read, in the cycle after the grant, arvalid SHALL assert (state RD_ADDR) and hold until arready.
- The block then enters RD_DATA with rready=1 and holds until rvalid.
REQ-021 On the B or R handshake the block SHALL:
- capture bresp or rresp (plus rdata) into cN_resp and cN_rdata of the granted requester;
- go to DONE.
- For writes, cN_rdata is unchanged.
REQ-022 In DONE, the block SHALL pulse cN_done for one cycle, then return to IDLE.
- A new grant is possible at the earliest on the cycle after DONE.
REQ-023 cN_rdata and cN_resp SHALL hold their values until that requester's next done.
REQ-024 Minimum latency, with the grant at cycle T and a zero-wait slave, SHALL be:
- valid at T+1;
- response handshake at T+2;
- done at T+3.
REQ-025 cN_valid deasserting while not yet granted SHALL be legal; a command is only taken on its ready pulse.
REQ-026 Non-OKAY responses SHALL be passed through unchanged; there is no retry.

Reset
REQ-027 While ARESET=1 at a rising edge, the block SHALL go to IDLE with last_grant=1, so that c0 wins the first contention.
- All m_axi_*valid, bready, rready, cN_ready and cN_done = 0.
- cN_rdata = 0 and cN_resp = 2'b00.
- All address and data outputs = 0.
REQ-028 Reset mid-transaction SHALL abandon the transaction with no done pulse; the system must also reset the AXI slave.

Verification
REQ-029 Single write: c0 writes addr 0x4, data 0x00000002, strb 0xF, zero-wait slave -> c0_ready at T, awaddr=0x4 with awvalid=wvalid=1 at T+1, c0_done at T+3, c0_resp=00.
REQ-030 Write then read back, across addr 0x0/0x4/0x8/0xC with data 1/2/3/4 -> each read gives c0_rdata equal to the written value, resp 00.
REQ-031 Contention: c0 and c1 both valid from reset -> grant order c0, c1, c0, c1 over four commands, and never two ready pulses in one cycle.
REQ-032 Skewed handshake: awready delayed 3 cycles and wready immediate -> wvalid drops after 1 cycle, awvalid holds 3 cycles, and WR_RESP is entered only after both.
REQ-033 Backpressure plus error: rvalid delayed 5 cycles with rresp=2'b10 -> rready held for 5 cycles, c1_resp=10, c1_done one pulse.
REQ-034 Reset asserted during RD_DATA -> next cycle all valids, bready and rready are 0, no done pulse, and the next contention grants c0.
